serial_sub: RTL and testbench

Parametrised multi-cycle subtractor computing `d = x - y - bin` over WIDTH-bit operands, DIGIT bits per clock.
- It chains DIGIT full-subtractor cells and feeds the borrow back through a register between cycles.
- It trades latency for area in datapaths that need wide subtraction without a wide ripple chain.
- A start/busy/done handshake lets a controlling FSM issue one operation at a time.

---
 rtl/serial_sub.sv | 115 +++++++++++
 tb/tb_serial_sub.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Digit-serial subtractor: d = x - y - bin over WIDTH bits, DIGIT bits per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

  // One-hot-style codes so busy/done come straight from state flops.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]       state;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] rs;
  logic             br;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig;
  logic             chain_b;
  logic             chain_bo;
  logic [WIDTH-1:0] rs_next;

`ifdef SERIAL_SUB_OVF_EN
  logic x_msb;
  logic y_msb;
`endif

  assign busy = state[0];
  assign done = state[1];

  always_comb begin
    dig     = '0;
    chain_b = br;
    for (int i = 0; i < DIGIT; i++) begin
      dig[i]  = xs[i] ^ ys[i] ^ chain_b;
      chain_b = (~xs[i] & ys[i]) | (~(xs[i] ^ ys[i]) & chain_b);
    end
    chain_bo = chain_b;
    rs_next  = (rs >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      xs    <= '0;
      ys    <= '0;
      rs    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            xs    <= x;
            ys    <= y;
            br    <= bin;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          xs  <= xs >> DIGIT;
          ys  <= ys >> DIGIT;
          rs  <= rs_next;
          br  <= chain_bo;
          cnt <= cnt + 1'b1;
          // Last digit: publish the assembled result including this digit.
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            d     <= rs_next;
            bout  <= chain_bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (x_msb ^ y_msb) & (rs_next[WIDTH-1] ^ x_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub in three configurations
// (8x1, 4x2 exhaustive back-to-back, 8x4), plus ovf when SERIAL_SUB_OVF_EN is set.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // 8-bit, 1 bit per clock
  logic       start_a = 1'b0;
  logic [7:0] x_a = '0, y_a = '0;
  logic       bin_a = 1'b0;
  logic       busy_a, done_a, bout_a;
  logic [7:0] d_a;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf_a;
`endif

  // 4-bit, 2 bits per clock
  logic       start_b = 1'b0;
  logic [3:0] x_b = '0, y_b = '0;
  logic       bin_b = 1'b0;
  logic       busy_b, done_b, bout_b;
  logic [3:0] d_b;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf_b;
`endif

  // 8-bit, 4 bits per clock
  logic       start_c = 1'b0;
  logic [7:0] x_c = '0, y_c = '0;
  logic       bin_c = 1'b0;
  logic       busy_c, done_c, bout_c;
  logic [7:0] d_c;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf_c;
`endif

  int assert_count = 0;
  int fail_count   = 0;
  int overlap_cnt  = 0;

  int         lat, busy_cnt, diff, ticks;
  logic [7:0] dv;
  logic       bov;
  logic [3:0] exp_d4;

  serial_sub #(.WIDTH(8), .DIGIT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x(x_a), .y(y_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .d(d_a), .bout(bout_a)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf_a)
`endif
  );

  serial_sub #(.WIDTH(4), .DIGIT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x(x_b), .y(y_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .d(d_b), .bout(bout_b)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf_b)
`endif
  );

  serial_sub #(.WIDTH(8), .DIGIT(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .x(x_c), .y(y_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .d(d_c), .bout(bout_c)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf_c)
`endif
  );

  always #5 clk = ~clk;

  // busy and done must never be seen together on any instance
  always @(negedge clk) begin
    if ((busy_a && done_a) || (busy_b && done_b) || (busy_c && done_c))
      overlap_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one operation on the 8x1 instance and wait (bounded) for done.
  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                               output logic [7:0] dout, output logic bo,
                               output int latency, output int nbusy);
    x_a = xv; y_a = yv; bin_a = bv; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    latency = 0;
    nbusy = busy_a ? 1 : 0;
    while (!done_a && latency < 40) begin
      tick();
      latency++;
      if (busy_a) nbusy++;
    end
    if (!done_a) checkOutput("op8_timeout", 32'd0, 32'd1);
    dout = d_a;
    bo   = bout_a;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy_a", busy_a, 0);
    checkOutput("rst_done_a", done_a, 0);
    checkOutput("rst_d_a", d_a, 0);
    checkOutput("rst_bout_a", bout_a, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    checkOutput("rst_busy_c", busy_c, 0);
    rst_n = 1'b1;
    tick();

    // 5 - 3
    applyStimulus(8'h05, 8'h03, 1'b0, dv, bov, lat, busy_cnt);
    checkOutput("t1_d", dv, 8'h02);
    checkOutput("t1_bout", bov, 0);
    checkOutput("t1_latency", lat, 8);
    checkOutput("t1_busy_cycles", busy_cnt, 8);
    tick();
    checkOutput("t1_done_pulse", done_a, 0);
    checkOutput("t1_d_held", d_a, 8'h02);
    checkOutput("t1_idle_busy", busy_a, 0);

    // underflow, then borrow-in
    applyStimulus(8'h00, 8'h01, 1'b0, dv, bov, lat, busy_cnt);
    checkOutput("t2a_d", dv, 8'hFF);
    checkOutput("t2a_bout", bov, 1);
    applyStimulus(8'h10, 8'h0F, 1'b1, dv, bov, lat, busy_cnt);
    checkOutput("t2b_d", dv, 8'h00);
    checkOutput("t2b_bout", bov, 0);
    applyStimulus(8'h00, 8'h02, 1'b0, dv, bov, lat, busy_cnt);
    checkOutput("t2c_d", dv, 8'hFE);
    checkOutput("t2c_bout", bov, 1);

    // start ignored during RUN (8x4)
    x_c = 8'h33; y_c = 8'h11; bin_c = 1'b0; start_c = 1'b1;
    tick();
    checkOutput("t4_busy_accept", busy_c, 1);
    x_c = 8'hFF; y_c = 8'h00; start_c = 1'b1;
    tick();
    checkOutput("t4_busy_run", busy_c, 1);
    checkOutput("t4_done_early", done_c, 0);
    start_c = 1'b0;
    tick();
    checkOutput("t4_done", done_c, 1);
    checkOutput("t4_d", d_c, 8'h22);
    checkOutput("t4_bout", bout_c, 0);
    tick();
    checkOutput("t4_idle_busy", busy_c, 0);
    checkOutput("t4_idle_done", done_c, 0);
    checkOutput("t4_d_held", d_c, 8'h22);

    // asynchronous reset mid-operation
    x_a = 8'hAA; y_a = 8'h55; bin_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    checkOutput("t5_busy_pre", busy_a, 1);
    checkOutput("t5_d_held_pre", d_a, 8'hFE);
    checkOutput("t5_bout_held_pre", bout_a, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_busy_async", busy_a, 0);
    checkOutput("t5_done_async", done_a, 0);
    checkOutput("t5_d_async", d_a, 0);
    checkOutput("t5_bout_async", bout_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("t5_idle_busy", busy_a, 0);
    checkOutput("t5_idle_done", done_a, 0);
    applyStimulus(8'h09, 8'h04, 1'b0, dv, bov, lat, busy_cnt);
    checkOutput("t5_d", dv, 8'h05);
    checkOutput("t5_bout", bov, 0);
    checkOutput("t5_latency", lat, 8);

`ifdef SERIAL_SUB_OVF_EN
    applyStimulus(8'h80, 8'h01, 1'b0, dv, bov, lat, busy_cnt);
    checkOutput("t6a_d", dv, 8'h7F);
    checkOutput("t6a_ovf", ovf_a, 1);
    applyStimulus(8'h7F, 8'h01, 1'b0, dv, bov, lat, busy_cnt);
    checkOutput("t6b_d", dv, 8'h7E);
    checkOutput("t6b_ovf", ovf_a, 0);
`endif

    // exhaustive 4x2 sweep, start held through DONE
    for (int i = 0; i < 512; i++) begin
      x_b = i[8:5]; y_b = i[4:1]; bin_b = i[0]; start_b = 1'b1;
      diff = int'(x_b) - int'(y_b) - int'(bin_b);
      exp_d4 = diff[3:0];
      ticks = 0;
      do begin
        tick();
        ticks++;
      end while (!done_b && ticks < 10);
      checkOutput($sformatf("sweep_spacing_%0d", i), ticks, 3);
      checkOutput($sformatf("sweep_d_%0d", i), d_b, exp_d4);
      checkOutput($sformatf("sweep_bout_%0d", i), bout_b, (diff < 0) ? 1 : 0);
    end
    start_b = 1'b0;
    tick();
    checkOutput("sweep_end_idle", busy_b, 0);
    tick();

    checkOutput("busy_done_overlap", overlap_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
